message_packetizer: RTL and testbench

- Converts a raw sample stream (one WIDTH-bit word per in_nd strobe) into message-stream packets: one header word followed by payload words.
- Sits directly upstream of the message stream combiner and drives one of its input streams.
- The output has no backpressure, so each packet is emitted as a contiguous burst once its payload is fully buffered.

---
 rtl/message_packetizer.sv | 136 +++++++++++++
 tb/tb_message_packetizer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/message_packetizer.sv
// ============================================================================
// Module      : message_packetizer
// Description : Buffers a raw sample stream and emits header+payload packets
//               as contiguous bursts for the message stream combiner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module message_packetizer #(
    parameter int WIDTH                 = 32,
    parameter int PACKET_LENGTH         = 16,
    parameter int LOG_MAX_PACKET_LENGTH = 10,
    parameter int BUFFER_LENGTH         = 64,
    parameter int LOG_BUFFER_LENGTH     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_nd,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_payload = 1'b1;

    localparam logic [LOG_BUFFER_LENGTH:0]       c_buf_full  = (LOG_BUFFER_LENGTH+1)'(BUFFER_LENGTH);
    localparam logic [LOG_BUFFER_LENGTH:0]       c_pkt_cnt   = (LOG_BUFFER_LENGTH+1)'(PACKET_LENGTH);
    localparam logic [LOG_BUFFER_LENGTH:0]       c_cnt_one   = (LOG_BUFFER_LENGTH+1)'(1);
    localparam logic [LOG_BUFFER_LENGTH-1:0]     c_ptr_one   = LOG_BUFFER_LENGTH'(1);
    localparam logic [LOG_MAX_PACKET_LENGTH-1:0] c_pkt_len   = LOG_MAX_PACKET_LENGTH'(PACKET_LENGTH);
    localparam logic [LOG_MAX_PACKET_LENGTH-1:0] c_len_one   = LOG_MAX_PACKET_LENGTH'(1);

    logic [WIDTH-1:0]                 r_mem [BUFFER_LENGTH];
    logic [LOG_BUFFER_LENGTH-1:0]     r_wr_ptr;
    logic [LOG_BUFFER_LENGTH-1:0]     r_rd_ptr;
    logic [LOG_BUFFER_LENGTH:0]       r_count;
    logic [0:0]                       r_state;
    logic [LOG_MAX_PACKET_LENGTH-1:0] r_remaining;
    logic                             r_flush_pending;

    logic                             w_pop;
    logic                             w_full;
    logic                             w_push;
    logic                             w_want_flush;
    logic                             w_has_full;
    logic                             w_idle_ready;
    logic                             w_launch;
    logic [LOG_MAX_PACKET_LENGTH-1:0] w_len;
    logic [WIDTH-1:0]                 w_header;

    assign w_pop        = (r_state == c_st_payload);
    assign w_full       = (r_count == c_buf_full) && !w_pop;
    assign w_push       = in_nd && !w_full;
    assign w_want_flush = flush || r_flush_pending;
    assign w_has_full   = (r_count >= c_pkt_cnt);
    // Holding off while out_nd is still high guarantees an idle cycle between packets.
    assign w_idle_ready = (r_state == c_st_idle) && !out_nd;
    assign w_launch     = w_idle_ready && (w_has_full || (w_want_flush && (r_count != '0)));
    assign w_len        = w_has_full ? c_pkt_len : LOG_MAX_PACKET_LENGTH'(r_count);

    always_comb begin
        w_header                                       = '0;
        w_header[WIDTH-1]                              = 1'b1;
        w_header[WIDTH-2 -: LOG_MAX_PACKET_LENGTH]     = w_len;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_state         <= c_st_idle;
            r_remaining     <= '0;
            r_flush_pending <= 1'b0;
            out_data        <= '0;
            out_nd          <= 1'b0;
            error           <= 1'b0;
        end else begin
            if (in_nd && w_full) begin
                error <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            out_nd <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        out_data        <= w_header;
                        out_nd          <= 1'b1;
                        r_remaining     <= w_len;
                        r_flush_pending <= 1'b0;
                        r_state         <= c_st_payload;
                    end else if (w_idle_ready && w_want_flush) begin
                        r_flush_pending <= 1'b0;
                    end else if (flush) begin
                        r_flush_pending <= 1'b1;
                    end
                end
                c_st_payload: begin
                    out_data    <= r_mem[r_rd_ptr];
                    out_nd      <= 1'b1;
                    r_remaining <= r_remaining - c_len_one;
                    if (r_remaining == c_len_one) begin
                        r_state <= c_st_idle;
                    end
                    if (flush) begin
                        r_flush_pending <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_message_packetizer.sv
// ============================================================================
// Module      : tb_message_packetizer
// Description : Directed vector bench for message_packetizer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_message_packetizer;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_nd;
    logic        flush;
    logic [31:0] out_data;
    logic        out_nd;
    logic        error;

    logic [31:0] in_data64;
    logic        in_nd64;
    logic        flush64;
    logic [31:0] out_data64;
    logic        out_nd64;
    logic        error64;

    int vectors     = 0;
    int miscompares = 0;
    int gap_viol    = 0;

    logic [31:0] mon_q[$];
    logic [31:0] exp_q[$];
    logic        prev_nd;

    message_packetizer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .flush    (flush),
        .out_data (out_data),
        .out_nd   (out_nd),
        .error    (error)
    );

    message_packetizer #(.PACKET_LENGTH(64)) dut64 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data64),
        .in_nd    (in_nd64),
        .flush    (flush64),
        .out_data (out_data64),
        .out_nd   (out_nd64),
        .error    (error64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every emitted word; a header directly after a valid word is a gap violation.
    initial prev_nd = 1'b0;
    always @(negedge clk) begin
        if (out_nd) begin
            mon_q.push_back(out_data);
            if (out_data[31] && prev_nd) gap_viol++;
        end
        prev_nd = out_nd;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        nd;
        logic [31:0] data;
        logic        fl;
        logic        exp_nd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[49];

    function automatic logic [31:0] hdr(input int l);
        hdr = 32'h8000_0000 | (32'(l) << 21);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_q(input string name);
        check({name, " len"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i),
                  (i < mon_q.size()) ? mon_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        end
    endtask

    initial begin
        // Table: full packet of 0x1..0x10, then a 5-word flushed packet, then an empty flush.
        for (int v = 0; v < 49; v++) tbl[v] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        for (int v = 0; v < 16; v++) begin
            tbl[v].nd   = 1'b1;
            tbl[v].data = 32'(v + 1);
        end
        tbl[16].exp_nd = 1'b1; tbl[16].exp_data = hdr(16);
        for (int v = 17; v <= 32; v++) begin
            tbl[v].exp_nd = 1'b1; tbl[v].exp_data = 32'(v - 16);
        end
        for (int v = 34; v <= 38; v++) begin
            tbl[v].nd = 1'b1; tbl[v].data = 32'hA0 + 32'(v - 34);
        end
        tbl[39].fl = 1'b1; tbl[39].exp_nd = 1'b1; tbl[39].exp_data = hdr(5);
        for (int v = 40; v <= 44; v++) begin
            tbl[v].exp_nd = 1'b1; tbl[v].exp_data = 32'hA0 + 32'(v - 40);
        end
        tbl[46].fl = 1'b1;

        rst_n = 1'b0; in_data = '0; in_nd = 1'b0; flush = 1'b0;
        in_data64 = '0; in_nd64 = 1'b0; flush64 = 1'b0;
        idle(2);
        check("reset out_nd", 32'(out_nd), 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset error64", 32'(error64), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 49; v++) begin
            in_nd = tbl[v].nd; in_data = tbl[v].data; flush = tbl[v].fl;
            tick();
            check($sformatf("tbl[%0d] out_nd", v), 32'(out_nd), 32'(tbl[v].exp_nd));
            if (tbl[v].exp_nd) check($sformatf("tbl[%0d] out_data", v), out_data, tbl[v].exp_data);
        end
        in_nd = 1'b0; flush = 1'b0;

        // Continuous stream of 40 words, then flush the 8 left over.
        mon_q.delete(); exp_q.delete();
        for (int i = 1; i <= 40; i++) begin
            in_nd = 1'b1; in_data = 32'(i);
            tick();
        end
        in_nd = 1'b0;
        idle(20);
        check("stream error", 32'(error), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        idle(15);
        exp_q.push_back(hdr(16)); for (int i = 1; i <= 16; i++) exp_q.push_back(32'(i));
        exp_q.push_back(hdr(16)); for (int i = 17; i <= 32; i++) exp_q.push_back(32'(i));
        exp_q.push_back(hdr(8));  for (int i = 33; i <= 40; i++) exp_q.push_back(32'(i));
        check_q("stream");

        // Flush during the payload of a full packet while 3 more words arrive.
        mon_q.delete(); exp_q.delete();
        for (int i = 1; i <= 16; i++) begin
            in_nd = 1'b1; in_data = 32'h100 + 32'(i);
            tick();
        end
        in_nd = 1'b0;
        idle(3);
        flush = 1'b1; in_nd = 1'b1; in_data = 32'h201; tick();
        flush = 1'b0; in_data = 32'h202; tick();
        in_data = 32'h203; tick();
        in_nd = 1'b0;
        idle(30);
        exp_q.push_back(hdr(16)); for (int i = 1; i <= 16; i++) exp_q.push_back(32'h100 + 32'(i));
        exp_q.push_back(hdr(3));  for (int i = 1; i <= 3; i++)  exp_q.push_back(32'h200 + 32'(i));
        check_q("midflush");

        // Overflow on the 64-word-packet instance: the 65th write meets a full FIFO.
        for (int j = 0; j < 70; j++) begin
            in_nd64 = 1'b1; in_data64 = 32'(j + 1);
            tick();
            if (j == 63) check("ovf error before full", 32'(error64), 32'd0);
            if (j == 64) begin
                check("ovf error on drop", 32'(error64), 32'd1);
                check("ovf header nd", 32'(out_nd64), 32'd1);
                check("ovf header", out_data64, hdr(64));
            end
            if (j == 65) check("ovf first payload", out_data64, 32'd1);
        end
        in_nd64 = 1'b0;
        idle(80);
        check("ovf error sticky", 32'(error64), 32'd1);

        // Asynchronous reset in the middle of a payload.
        mon_q.delete(); exp_q.delete();
        for (int i = 1; i <= 16; i++) begin
            in_nd = 1'b1; in_data = 32'h300 + 32'(i);
            tick();
        end
        in_nd = 1'b0;
        idle(5);
        check("pre-reset out_nd", 32'(out_nd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_nd", 32'(out_nd), 32'd0);
        check("async reset error64", 32'(error64), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset out_nd", 32'(out_nd), 32'd0);
        mon_q.delete();
        flush = 1'b1; tick(); flush = 1'b0;
        idle(4);
        check("post-reset fifo empty", 32'(mon_q.size()), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            in_nd = 1'b1; in_data = 32'h400 + 32'(i);
            tick();
        end
        in_nd = 1'b0;
        idle(25);
        exp_q.push_back(hdr(16)); for (int i = 1; i <= 16; i++) exp_q.push_back(32'h400 + 32'(i));
        check_q("post-reset packet");
        check("post-reset error", 32'(error), 32'd0);
        check("inter-packet gap violations", 32'(gap_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
